// File: rtl/quadrature_emitter_pkg.sv
// Shared types for the quadrature emitter and its matching encoder counter:
// FSM states, the four {A,B} phase encodings and phase stepping helpers.
package quad_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Phase values are the literal {A,B} pattern driven onto the pins.
  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_10 = 2'b10,
    PH_11 = 2'b11,
    PH_01 = 2'b01
  } phase_t;

  // Forward order is 00 -> 10 -> 11 -> 01 -> 00.
  function automatic phase_t next_phase(input phase_t p);
    case (p)
      PH_00:   return PH_10;
      PH_10:   return PH_11;
      PH_11:   return PH_01;
      default: return PH_00;
    endcase
  endfunction

  // Reverse order is the exact inverse of next_phase.
  function automatic phase_t prev_phase(input phase_t p);
    case (p)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      default: return PH_00;
    endcase
  endfunction

endpackage

// File: rtl/quadrature_emitter_if.sv
// Command handshake between a motion controller and the quadrature emitter.
interface quadrature_emitter_if #(
  parameter int STEP_W = 8,
  parameter int PER_W  = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [STEP_W-1:0] cmd_steps;
  logic [PER_W-1:0]  cmd_period;
  logic              abort;

  modport master (
    output cmd_valid, cmd_steps, cmd_period, abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_steps, cmd_period, abort,
    output cmd_ready
  );
endinterface

// File: rtl/quadrature_emitter_step_timer.sv
// Reloadable down-counter that paces quadrature edges. It ticks while
// running whenever the count sits at 1, then reloads the stored period so
// successive ticks are exactly one period apart.
module step_timer #(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  input  logic [PER_W-1:0] period,
  output logic             tick
);

  logic [PER_W-1:0] count_q;
  logic [PER_W-1:0] per_q;

  assign tick = run && (count_q == PER_W'(1));

  // Load on command acceptance, otherwise count down and reload on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      per_q   <= '0;
    end else if (load) begin
      count_q <= period;
      per_q   <= period;
    end else if (run) begin
      if (count_q == PER_W'(1)) count_q <= per_q;
      else                      count_q <= count_q - PER_W'(1);
    end
  end

endmodule

// File: rtl/quadrature_emitter.sv
// Quadrature emitter: turns a signed step command into a paced A/B
// quadrature sequence and mirrors the count a matching decoder would report.
module quadrature_emitter
  import quad_pkg::*;
#(
  parameter int CNT_W  = 5,
  parameter int STEP_W = 8,
  parameter int PER_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  quadrature_emitter_if.slave  cmd,
  output logic                 a,
  output logic                 b,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     position
);

  state_t            state_q, state_d;
  phase_t            phase_q;
  logic              ready_q;
  logic              done_q, done_d;
  logic              zero_pend_q;
  logic              dir_q;
  logic [STEP_W-1:0] remaining_q;
  logic [STEP_W-1:0] steps_abs;
  logic [PER_W-1:0]  per_eff;
  logic [CNT_W-1:0]  pos_q;
  logic              accept;
  logic              tick;
  logic              edge_fire;

  // ready_q keeps cmd_ready low until the first clock after reset releases.
  assign cmd.cmd_ready = ready_q && (state_q == IDLE);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  // Magnitude fits in STEP_W unsigned bits, including the most negative value.
  assign steps_abs = cmd.cmd_steps[STEP_W-1] ? (~cmd.cmd_steps + STEP_W'(1))
                                             : cmd.cmd_steps;
  assign per_eff   = (cmd.cmd_period == '0) ? PER_W'(1) : cmd.cmd_period;

  // Abort beats a due edge; once remaining hits zero no further edges fire.
  assign edge_fire = (state_q == RUN) && tick && !cmd.abort && (remaining_q != '0);

  assign a        = phase_q[1];
  assign b        = phase_q[0];
  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign position = pos_q;

  step_timer #(.PER_W(PER_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .run    (state_q == RUN),
    .period (per_eff),
    .tick   (tick)
  );

  // Next-state and done decode; a zero-step command finishes from IDLE.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        done_d = zero_pend_q;
        if (accept && (steps_abs != '0)) state_d = RUN;
      end
      RUN: begin
        if (cmd.abort || (remaining_q == '0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  // State, done pulse and post-reset ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      ready_q <= 1'b1;
    end
  end

  // Capture the command on acceptance and count down emitted steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q <= '0;
      dir_q       <= 1'b0;
      zero_pend_q <= 1'b0;
    end else begin
      zero_pend_q <= accept && (steps_abs == '0);
      if (accept) begin
        remaining_q <= steps_abs;
        dir_q       <= cmd.cmd_steps[STEP_W-1];
      end else if (edge_fire) begin
        remaining_q <= remaining_q - STEP_W'(1);
      end
    end
  end

  // Advance phase and position together so they never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_00;
      pos_q   <= '0;
    end else if (edge_fire) begin
      if (dir_q) begin
        phase_q <= prev_phase(phase_q);
        pos_q   <= pos_q - CNT_W'(1);
      end else begin
        phase_q <= next_phase(phase_q);
        pos_q   <= pos_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/quadrature_emitter.md
QUADRATURE_EMITTER -- requirements
Module: quadrature_emitter

Interface
REQ-001 Parameter CNT_W, default 5, SHALL set the width of the position mirror, matching the encoder counter width.
REQ-002 Parameter STEP_W, default 8, SHALL set the width of the signed step command.
REQ-003 Parameter PER_W, default 16, SHALL set the width of the step period in CLK cycles.
REQ-004 CLK  input  1  SHALL be the single 16 MHz clock; all state is on its rising edge.
REQ-005 RST_N  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  SHALL mark a command as present.
REQ-007 cmd_ready  output  1  SHALL mark that the block can accept a command.
REQ-008 cmd_steps  input  STEP_W  SHALL give the signed step count: positive = forward, negative = reverse.
REQ-009 cmd_period  input  PER_W  SHALL give the number of CLK cycles between edges.
REQ-010 abort  input  1  SHALL request termination of the running command.
REQ-011 A, B  output  1 each  SHALL carry the emulated quadrature pair, direct from flops.
REQ-012 busy  output  1  SHALL be high while a command is executing.
REQ-013 done  output  1  SHALL be a one-cycle pulse marking command completion or abort.
REQ-014 position  output  CNT_W  SHALL be the running edge count a matching decoder reports.

Function
REQ-015 The state machine SHALL have exactly two states, IDLE and RUN; cmd_ready = (state==IDLE) and busy = (state==RUN).
REQ-016 A command SHALL be accepted on any cycle where cmd_valid && cmd_ready.
- On acceptance: remaining = |cmd_steps|, dir = sign, per = max(cmd_period,1), timer = per.
- Next state: RUN if remaining != 0, otherwise IDLE.
REQ-017 An accepted command with cmd_steps == 0 SHALL pulse done on the following cycle and emit no edge.
REQ-018 In RUN, the timer SHALL decrement each cycle; when it reaches 1, the next cycle SHALL:
- advance the phase one step;
- reload timer = per;
- decrement remaining.
REQ-019 The first edge SHALL appear exactly per cycles after the accept cycle, and successive edges SHALL be exactly per cycles apart.
REQ-020 Phase {A,B} forward sequence SHALL be 00->10->11->01->00; reverse SHALL be the exact inverse.
REQ-021 Exactly one of A or B SHALL change per step.
REQ-022 Phase SHALL persist across commands; a new command continues from the current phase.
REQ-023 position SHALL update in the same cycle as each edge: +1 for forward, -1 for reverse, modulo 2^CNT_W.
- Wrap: 31+1 -> 0 and 0-1 -> 31 at default width.
REQ-024 When the edge that brings remaining to 0 is emitted, the next cycle SHALL pulse done and enter IDLE.
REQ-025 cmd_valid SHALL be ignored while in RUN; no queueing.
REQ-026 abort in RUN SHALL, on the next cycle, enter IDLE and pulse done.
- A, B and position hold their current values.
- If an edge is due in the same cycle as abort, abort wins and the edge is not emitted.
REQ-027 abort in IDLE SHALL have no effect, and SHALL have no effect if it coincides with acceptance.
REQ-028 The most negative cmd_steps value SHALL give remaining = 2^(STEP_W-1), with no overflow.

Reset
REQ-029 While RST_N is low, the block SHALL hold: state=IDLE, A=0, B=0, position=0, busy=0, done=0, cmd_ready=0.
REQ-030 On the first CLK edge after RST_N deasserts, the block SHALL assert cmd_ready.
REQ-031 Reset mid-RUN SHALL abandon the command without a done pulse.

Structure
REQ-032 Package quad_pkg SHALL hold:
- the state enumeration;
- the four phase encodings, with next/previous phase lookup functions.
REQ-033 The counters in the reference encoder counter SHALL import the same package.
REQ-034 One sub-module, step_timer, SHALL implement the reloadable down-counter and its one-cycle tick output.
REQ-035 Twelve instances SHALL be supported for loopback of all motors in the hardware-in-loop top.

Verification
REQ-036 Reset, then cmd_steps=+4, cmd_period=3 -> edges at accept+3, +6, +9, +12; {A,B} = 10,11,01,00; position=4; done at accept+13.
REQ-037 From position 0, cmd_steps=-2, cmd_period=0 -> edges 1 cycle apart; {A,B} = 01,11; position=30; done pulses once.
REQ-038 cmd_steps=+40, period=1, from 0 -> position wraps to 8; every cycle exactly one of A or B toggles.
REQ-039 cmd_steps=+10, period=5; abort asserted on the cycle an edge is due after 3 edges -> no 4th edge; position=3; done next cycle; cmd_ready high.
REQ-040 cmd_steps=0 -> done on the cycle after accept; A, B and position unchanged; cmd_valid held during RUN of a later command -> ignored.
REQ-041 Loopback to the encoder counter at period=2 for ±20 steps -> counter value equals position on every cycle after a 2-cycle synchronizer lag.
